// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response valid-ready channels between the core and the memory responder
interface mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory with byte strobes, programmable wait states and error flagging
module mem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input logic           clk,
   input logic           reset,
   mem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {BOOT, IDLE, WAIT, RESP} state_t;
   state_t        r_state, w_next;
   logic [3:0]    r_cnt, w_cnt;
   logic [AW-1:0] r_idx, w_idx;
   logic          r_write, r_err, r_rsp_err;
   logic [31:0]   r_wdata, r_rdata, w_wdata;
   logic [3:0]    r_wstrb, w_wstrb;
   logic          w_accept, w_exec, w_req_err, w_write, w_err;
   logic [31:0]   r_mem [DEPTH];
   assign w_accept  = (r_state == IDLE) && bus.req_valid;
   assign w_req_err = (|bus.req_addr[1:0]) || ({2'b0, bus.req_addr[31:2]} >= 32'(DEPTH));
   // With zero wait states the access executes on the accept edge, straight from the request
   assign w_idx   = (r_state == IDLE) ? bus.req_addr[AW+1:2] : r_idx;
   assign w_write = (r_state == IDLE) ? bus.req_write : r_write;
   assign w_err   = (r_state == IDLE) ? w_req_err : r_err;
   assign w_wdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;
   assign w_wstrb = (r_state == IDLE) ? bus.req_wstrb : r_wstrb;
   always_comb begin
      w_next = r_state;
      w_cnt  = r_cnt;
      w_exec = 1'b0;
      case (r_state)
         BOOT: w_next = IDLE;
         IDLE: if (w_accept) begin
            w_next = (LATENCY == 0) ? RESP : WAIT;
            w_exec = (LATENCY == 0);
            w_cnt  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
         end
         WAIT: begin
            w_next = (r_cnt == 4'd0) ? RESP : WAIT;
            w_exec = (r_cnt == 4'd0);
            w_cnt  = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
         end
         RESP: w_next = bus.rsp_ready ? IDLE : RESP;
         default: w_next = BOOT;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= BOOT;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_write   <= 1'b0;
         r_err     <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_rdata   <= '0;
         r_rsp_err <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt;
         if (w_accept) begin
            r_idx   <= bus.req_addr[AW+1:2];
            r_write <= bus.req_write;
            r_err   <= w_req_err;
            r_wdata <= bus.req_wdata;
            r_wstrb <= bus.req_wstrb;
         end
         if (w_exec) begin
            r_rdata   <= (w_write || w_err) ? 32'd0 : r_mem[w_idx];
            r_rsp_err <= w_err;
         end else if (r_state == RESP && bus.rsp_ready) begin
            r_rdata   <= '0;
            r_rsp_err <= 1'b0;
         end
      end
   end
   // Storage is deliberately outside the reset domain so contents survive reset
   always_ff @(posedge clk) begin
      if (w_exec && w_write && !w_err)
         for (int i = 0; i < 4; i++)
            if (w_wstrb[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
   end
   assign bus.req_ready = (r_state == IDLE);
   assign bus.rsp_valid = (r_state == RESP);
   assign bus.rsp_rdata = r_rdata;
   assign bus.rsp_err   = r_rsp_err;
endmodule
